// File: rtl/cim_ctrl_pkg.sv
// rtl/cim_ctrl_pkg.sv - shared types and defaults for the CIM row-path command sequencer
package cim_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'd0,
      OP_READ   = 2'd1,
      OP_MAC    = 2'd2,
      OP_SEARCH = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_ACC  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam int PRE_CYC_DEF = 1;
   localparam int WR_CYC_DEF  = 2;

   // Phase counter must hold the longest of the precharge, write and MAC phases.
   function automatic int cnt_width(input int pre_cyc, input int wr_cyc);
      int m;
      m = (pre_cyc > wr_cyc) ? pre_cyc : wr_cyc;
      if (m < 2) m = 2;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/cim_seq_ctrl_if.sv
// rtl/cim_seq_ctrl_if.sv - host command handshake and status bundle
interface cim_seq_ctrl_if #(
   parameter int AW = 2,
   parameter int DW = 4
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic          cmd_rbar;
   logic [DW-1:0] cmd_data;
   logic          abort;
   logic          busy;
   logic          done;
   logic          aborted;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_rbar, cmd_data, abort,
      input  cmd_ready, busy, done, aborted
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_rbar, cmd_data, abort,
      output cmd_ready, busy, done, aborted
   );
endinterface

// File: rtl/cim_phase_cnt.sv
// rtl/cim_phase_cnt.sv - loadable saturating down-counter with terminal-count flag
module cim_phase_cnt #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          tc
);
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           cnt <= '0;
      else if (load)        cnt <= load_val;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign tc = (cnt == '0);
endmodule

// File: rtl/cim_seq_ctrl.sv
// rtl/cim_seq_ctrl.sv - row-path command sequencer: precharge, access and done phases
module cim_seq_ctrl
   import cim_ctrl_pkg::*;
#(
   parameter int ROWS    = 4,
   parameter int AW      = 2,
   parameter int DW      = 4,
   parameter int PRE_CYC = PRE_CYC_DEF,
   parameter int WR_CYC  = WR_CYC_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   cim_seq_ctrl_if.slave cmd,
   output logic          cs,
   output logic          MAC_en,
   output logic          read_bar,
   output logic          w_en,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data
);
   localparam int            CW       = cnt_width(PRE_CYC, WR_CYC);
   localparam logic [CW-1:0] PRE_LD   = CW'(PRE_CYC - 1);
   localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

   state_e        state_q, state_n;
   op_e           op_q;
   logic [AW-1:0] addr_q, row_q, row_n;
   logic          rbar_q;
   logic [DW-1:0] data_q;
   logic          latch, cnt_load, cnt_tc;
   logic [CW-1:0] cnt_val;

   logic          cs_n, mac_n, rbar_n, wen_n, rdy_n, busy_n, done_n, abrt_n;
   logic [AW-1:0] addr_n;
   logic [DW-1:0] data_n;
   logic          rdy_q, busy_q, done_q, abrt_q;

   function automatic logic [CW-1:0] acc_ld(input op_e op);
      case (op)
         OP_WRITE: return CW'(WR_CYC - 1);
         OP_MAC:   return CW'(1);
         default:  return '0;
      endcase
   endfunction

   cim_phase_cnt #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tc       (cnt_tc)
   );

   always_comb begin
      state_n = state_q;
      row_n   = row_q;
      latch   = 1'b0;
      cnt_val = '0;
      abrt_n  = 1'b0;
      case (state_q)
         S_IDLE: if (cmd.cmd_valid) begin
            latch   = 1'b1;
            row_n   = '0;
            state_n = S_PRE;
            cnt_val = PRE_LD;
         end
         S_PRE: if (cmd.abort) begin
            state_n = S_DONE;
            abrt_n  = 1'b1;
         end else if (cnt_tc) begin
            state_n = S_ACC;
            cnt_val = acc_ld(op_q);
         end
         // Abort is checked first so it wins over the natural end of the access.
         S_ACC: if (cmd.abort) begin
            state_n = S_DONE;
            abrt_n  = 1'b1;
         end else if (cnt_tc) begin
            if (op_q == OP_MAC && row_q != LAST_ROW) begin
               state_n = S_PRE;
               row_n   = row_q + 1'b1;
               cnt_val = PRE_LD;
            end else begin
               state_n = S_DONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      cnt_load = (state_n != state_q);

      // Outputs are decoded from the next state so they register alongside it.
      cs_n   = 1'b0;
      mac_n  = 1'b0;
      rbar_n = 1'b0;
      wen_n  = 1'b0;
      addr_n = '0;
      data_n = '0;
      rdy_n  = 1'b0;
      busy_n = 1'b1;
      done_n = 1'b0;
      case (state_n)
         S_IDLE: begin
            rdy_n  = 1'b1;
            busy_n = 1'b0;
         end
         S_ACC: begin
            cs_n = 1'b1;
            case (op_q)
               OP_WRITE: begin
                  wen_n  = 1'b1;
                  addr_n = addr_q;
                  data_n = data_q;
               end
               OP_READ: begin
                  mac_n  = 1'b1;
                  rbar_n = rbar_q;
                  addr_n = addr_q;
               end
               OP_MAC: begin
                  mac_n  = 1'b1;
                  rbar_n = (state_q == S_ACC);
                  addr_n = row_n;
               end
               default: data_n = data_q;
            endcase
         end
         S_DONE: done_n = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_WRITE;
         addr_q   <= '0;
         rbar_q   <= 1'b0;
         data_q   <= '0;
         row_q    <= '0;
         cs       <= 1'b0;
         MAC_en   <= 1'b0;
         read_bar <= 1'b0;
         w_en     <= 1'b0;
         addr     <= '0;
         data     <= '0;
         rdy_q    <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         abrt_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         row_q   <= row_n;
         if (latch) begin
            op_q   <= op_e'(cmd.cmd_op);
            addr_q <= cmd.cmd_addr;
            rbar_q <= cmd.cmd_rbar;
            data_q <= cmd.cmd_data;
         end
         cs       <= cs_n;
         MAC_en   <= mac_n;
         read_bar <= rbar_n;
         w_en     <= wen_n;
         addr     <= addr_n;
         data     <= data_n;
         rdy_q    <= rdy_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         abrt_q   <= abrt_n;
      end
   end

   assign cmd.cmd_ready = rdy_q;
   assign cmd.busy      = busy_q;
   assign cmd.done      = done_q;
   assign cmd.aborted   = abrt_q;
endmodule
